oh_rr_grant_sched: RTL
======================

// Module: oh_rr_grant_sched
// PURPOSE
//  Round-robin scheduler that shares one downstream resource among NumReq requesters.
//  - Holds a registered one-hot grant until the downstream consumer accepts it.
//  - Emits the same grant as a binary index, produced by a one-hot-to-uint encode.
//  - Sits in front of shared commoncell datapaths such as a shared port or a
//    refill/writeback slot.
// PARAMETERS
//  NumReq    default 4                  number of requesters, >=2
//  IdxWidth  default $clog2(NumReq)     width of the binary grant index (derived, do not override)
// PORTS
//  clk          in   1         single clock, rising edge
//  rst          in   1         asynchronous active-high reset
//  req_i        in   NumReq    per-requester request, level; held until granted
//  gnt_valid_o  out  1         a grant is presented
//  gnt_ready_i  in   1         downstream accepts; handshake = gnt_valid_o & gnt_ready_i
//  gnt_oh_o     out  NumReq    one-hot grant, registered; all-zero when !gnt_valid_o
//  gnt_idx_o    out  IdxWidth  binary index of gnt_oh_o; 0 when !gnt_valid_o
//  lock_i       in   1         [ARB_LOCK_EN only] keep current winner for next grant
// BEHAVIOUR
//  Reset (async, rst=1):
//  - state=IDLE, prio_ptr=0.
//  - gnt_valid_o=0, gnt_oh_o=0, gnt_idx_o=0.
//  State machine:
//  - IDLE: if |req_i -> GRANT, loading the round-robin winner into gnt_oh_o.
//  - GRANT: gnt_valid_o=1; gnt_oh_o and gnt_idx_o stable while !gnt_ready_i.
//  - On a handshake: prio_ptr <= winner_idx+1, wrapping NumReq-1 -> 0.
//    - Same edge, if another request is pending (req_i excluding the winner, with
//      the new pointer) -> stay in GRANT with the new winner (back-to-back, 1 grant/cycle).
//    - Otherwise -> IDLE.
//  Arbitration:
//  - Winner = first set bit of req_i searching upward from prio_ptr, wrapping.
//  - Implemented as a double-width masked priority pick.
//  - The just-served requester has the lowest priority on the next pick.
//  Latency and stability:
//  - Latency: req_i rising in IDLE -> gnt_valid_o=1 the next cycle (1 cycle).
//  - gnt_idx_o is a combinational encode of registered gnt_oh_o; no extra cycle.
//  - No grant revocation: a winner that drops req_i while granted keeps the grant until handshake.
//  - gnt_ready_i while gnt_valid_o=0 is ignored; prio_ptr changes only on a handshake.
//  Reset mid-grant:
//  - Outputs clear asynchronously and the pending grant is dropped, no handshake counted.
//  - Arbitration restarts from requester 0.
//  Widths:
//  - prio_ptr is IdxWidth bits; wrap is explicit, so non-power-of-two NumReq is legal.
//  - One-hot invariant: $onehot0(gnt_oh_o) at all times.
// CONFIGURATION
//  ARB_LOCK_EN defined:
//  - Adds lock_i.
//  - A handshake with lock_i=1 while the winner's req_i=1 re-grants the same requester
//    next cycle and prio_ptr does not advance (bursts).
//  - A lock with the winner's req_i=0 is ignored; normal round-robin applies.
//  ARB_LOCK_EN undefined:
//  - No lock_i port; pure round-robin as above.
// TESTING
//  T1 Reset:
//  - rst=1 mid-GRANT -> same-cycle gnt_valid_o=0, gnt_oh_o=0.
//  - After release with req_i=4'b1111 -> first gnt_oh_o=4'b0001, gnt_idx_o=0.
//  T2 Rotation:
//  - req_i=4'b1111, gnt_ready_i=1 -> grants 0001,0010,0100,1000,0001 on consecutive
//    cycles, idx 0,1,2,3,0.
//  T3 Backpressure:
//  - req_i=4'b0110, gnt_ready_i=0 for 5 cycles -> gnt_oh_o=0010 stable, idx=1.
//  - On ready=1 -> next grant 0100.
//  T4 Sparse/wrap:
//  - Serve idx 3, then req_i=4'b1001 -> next grant 0001 (wrap), then 1000.
//  T5 Idle:
//  - req_i=0 -> gnt_valid_o=0, idx=0.
//  - A single req_i[2] pulse held -> grant 0100 one cycle later; NumReq=3 run repeats T2
//    with idx 0,1,2,0.
//  T6 ARB_LOCK_EN:
//  - req_i=4'b0011, lock_i=1 on 3 handshakes -> grant 0001 x4; lock_i=0 -> 0010 next.

Source files
------------

// File: rtl/oh_rr_grant_sched.sv
// Round-robin grant scheduler: a registered one-hot grant plus its binary index, held until the consumer accepts it.
// Optional ARB_LOCK_EN adds lock_i, which re-grants the current winner for bursts.
module oh_rr_grant_sched #(
    parameter int NumReq   = 4,
    parameter int IdxWidth = $clog2(NumReq)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NumReq-1:0]   req_i,
    output logic                gnt_valid_o,
    input  logic                gnt_ready_i,
    output logic [NumReq-1:0]   gnt_oh_o,
    output logic [IdxWidth-1:0] gnt_idx_o
`ifdef ARB_LOCK_EN
    ,
    input  logic                lock_i
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [IdxWidth-1:0]   prio_ptr_q, prio_ptr_d;
    logic [NumReq-1:0]     gnt_oh_q, gnt_oh_d;
    logic [IdxWidth-1:0]   winner_idx;
    logic [IdxWidth-1:0]   ptr_after;
    logic [NumReq-1:0]     next_pick;
    logic                  handshake;
    logic                  lock_hold;

    // Double the request vector, with the lower copy masked below ptr, so the
    // first set bit from the bottom is the wrapped search starting at ptr.
    function automatic logic [NumReq-1:0] rr_pick(input logic [NumReq-1:0]   req,
                                                  input logic [IdxWidth-1:0] ptr);
        logic [2*NumReq-1:0] dbl;
        logic [2*NumReq-1:0] first;
        logic [NumReq-1:0]   mask;
        logic                found;
        for (int i = 0; i < NumReq; i++) begin
            mask[i] = (i >= int'(ptr));
        end
        dbl   = {req, req & mask};
        first = '0;
        found = 1'b0;
        for (int i = 0; i < 2*NumReq; i++) begin
            if (dbl[i] && !found) begin
                first[i] = 1'b1;
                found    = 1'b1;
            end
        end
        return first[NumReq-1:0] | first[2*NumReq-1:NumReq];
    endfunction

    function automatic logic [IdxWidth-1:0] oh_to_idx(input logic [NumReq-1:0] oh);
        logic [IdxWidth-1:0] idx;
        idx = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (oh[i]) begin
                idx = idx | IdxWidth'(i);
            end
        end
        return idx;
    endfunction

    assign winner_idx = oh_to_idx(gnt_oh_q);
    assign handshake  = (state_q == GRANT) && gnt_ready_i;
    assign ptr_after  = (winner_idx == IdxWidth'(NumReq - 1)) ? '0 : winner_idx + 1'b1;
    assign next_pick  = rr_pick(req_i & ~gnt_oh_q, ptr_after);

`ifdef ARB_LOCK_EN
    // A lock only holds while the winner is still requesting.
    assign lock_hold = lock_i && |(req_i & gnt_oh_q);
`else
    assign lock_hold = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            prio_ptr_q <= '0;
            gnt_oh_q   <= '0;
        end else begin
            state_q    <= state_d;
            prio_ptr_q <= prio_ptr_d;
            gnt_oh_q   <= gnt_oh_d;
        end
    end

    // NOTE: every target gets a default before the case so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        prio_ptr_d = prio_ptr_q;
        gnt_oh_d   = gnt_oh_q;
        unique case (state_q)
            IDLE: begin
                if (|req_i) begin
                    state_d  = GRANT;
                    gnt_oh_d = rr_pick(req_i, prio_ptr_q);
                end
            end
            GRANT: begin
                if (handshake && !lock_hold) begin
                    prio_ptr_d = ptr_after;
                    if (|next_pick) begin
                        gnt_oh_d = next_pick;
                    end else begin
                        state_d  = IDLE;
                        gnt_oh_d = '0;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                gnt_oh_d = '0;
            end
        endcase
    end

    always_comb begin
        gnt_valid_o = (state_q == GRANT);
        gnt_oh_o    = gnt_oh_q;
        gnt_idx_o   = winner_idx;
    end

endmodule
